// File: rtl/channel_tdma_sched.sv
// Round-robin TDMA scheduler sharing one 9-bit channel between four sample sources.
// Define CHAN_SCHED_GUARD_EN to add a GUARD_LEN-cycle idle gap after every slot.
module channel_tdma_sched #(
    parameter int unsigned SLOT_LEN  = 8,
    parameter int unsigned GUARD_LEN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  s_valid,
    input  logic [35:0] s_data,
    output logic [3:0]  s_ready,
    output logic        tx_en,
    output logic [8:0]  tx_data,
    output logic [1:0]  tx_owner,
    output logic        slot_start,
    output logic        busy
);

    localparam logic [7:0] LAST_BEAT = 8'(SLOT_LEN - 1);

`ifdef CHAN_SCHED_GUARD_EN
    typedef enum logic [1:0] {IDLE, SLOT, GUARD} state_t;
    localparam logic [3:0] LAST_GUARD = 4'(GUARD_LEN - 1);
    logic [3:0] guard_cnt, guard_cnt_n;
`else
    typedef enum logic {IDLE, SLOT} state_t;
`endif

    state_t     state, state_n;
    logic [1:0] owner, owner_n;
    logic [1:0] last_owner, last_owner_n;
    logic [7:0] beat_cnt, beat_cnt_n;
    logic       tx_en_n, slot_start_n;
    logic [8:0] tx_data_n;
    logic [8:0] owner_sample;
    logic [1:0] grant_idx, cand;
    logic       grant_found;
    logic       slot_end;

    always_comb begin
        owner_sample = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (owner == 2'(i)) owner_sample = s_data[9*i +: 9];
        end
    end

    // Search upward from last_owner+1, wrapping, so the previous grantee has lowest priority.
    always_comb begin
        grant_idx   = last_owner;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_owner + 2'(i);
            if (!grant_found && s_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        beat_cnt_n   = beat_cnt;
        tx_en_n      = 1'b0;
        tx_data_n    = '0;
        slot_start_n = 1'b0;
        slot_end     = 1'b0;
`ifdef CHAN_SCHED_GUARD_EN
        guard_cnt_n  = guard_cnt;
`endif
        case (state)
            IDLE: begin
                if (grant_found) begin
                    owner_n      = grant_idx;
                    beat_cnt_n   = '0;
                    slot_start_n = 1'b1;
                    state_n      = SLOT;
                end
            end
            SLOT: begin
                if (s_valid[owner]) begin
                    tx_en_n    = 1'b1;
                    tx_data_n  = owner_sample;
                    beat_cnt_n = beat_cnt + 8'd1;
                    slot_end   = (beat_cnt == LAST_BEAT);
                end else begin
                    slot_end   = 1'b1;
                end
                if (slot_end) begin
                    last_owner_n = owner;
`ifdef CHAN_SCHED_GUARD_EN
                    guard_cnt_n  = '0;
                    state_n      = GUARD;
`else
                    state_n      = IDLE;
`endif
                end
            end
`ifdef CHAN_SCHED_GUARD_EN
            GUARD: begin
                if (guard_cnt == LAST_GUARD) state_n = IDLE;
                else guard_cnt_n = guard_cnt + 4'd1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= 2'd3;
            beat_cnt   <= '0;
            tx_en      <= 1'b0;
            tx_data    <= '0;
            slot_start <= 1'b0;
`ifdef CHAN_SCHED_GUARD_EN
            guard_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            beat_cnt   <= beat_cnt_n;
            tx_en      <= tx_en_n;
            tx_data    <= tx_data_n;
            slot_start <= slot_start_n;
`ifdef CHAN_SCHED_GUARD_EN
            guard_cnt  <= guard_cnt_n;
`endif
        end
    end

    assign s_ready  = (state == SLOT) ? (4'b0001 << owner) : '0;
    assign tx_owner = owner;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_channel_tdma_sched.sv
// Self-checking bench for channel_tdma_sched: random source bursts against a slot-level model.
module tb_channel_tdma_sched;
    localparam int unsigned SLOT_LEN  = 8;
    localparam int unsigned GUARD_LEN = 2;
`ifdef CHAN_SCHED_GUARD_EN
    localparam int GAP = GUARD_LEN + 2;
`else
    localparam int GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s_valid = '0;
    logic [35:0] s_data = '0;
    logic [3:0]  s_ready;
    logic        tx_en;
    logic [8:0]  tx_data;
    logic [1:0]  tx_owner;
    logic        slot_start;
    logic        busy;

    channel_tdma_sched #(.SLOT_LEN(SLOT_LEN), .GUARD_LEN(GUARD_LEN)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_owner(tx_owner),
        .slot_start(slot_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] sdata [4][64];
    int         cnt [4];
    int         pos [4];
    int         m_last;

    logic [8:0] obs_data [$];
    logic [1:0] obs_owner [$];
    logic       obs_en [$];
    logic       obs_busy [$];
    logic [8:0] exp_data [$];
    logic [1:0] exp_owner [$];

    task automatic wait_cycle();
        @(posedge clk); #1;
    endtask

    task automatic drive_sources();
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = (pos[i] < cnt[i]);
            s_data[9*i +: 9] = (pos[i] < cnt[i]) ? sdata[i][pos[i]] : 9'h0;
        end
    endtask

    task automatic apply_reset();
        s_valid = '0;
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        wait_cycle();
        m_last = 3;
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3, input bit ramp);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0;
            for (int k = 0; k < 64; k++) sdata[i][k] = ramp ? 9'(k + 1) : 9'($urandom);
        end
    endtask

    // Slot-level reference: round-robin over requesters with samples left, up to SLOT_LEN per grant.
    task automatic build_expected();
        int left [4];
        int p [4];
        int o, n;
        bit any;
        exp_data.delete();
        exp_owner.delete();
        for (int i = 0; i < 4; i++) begin
            left[i] = cnt[i] - pos[i];
            p[i] = pos[i];
        end
        any = 1'b1;
        while (any) begin
            o = -1;
            for (int j = 1; j <= 4; j++) begin
                if (o < 0 && left[(m_last + j) % 4] > 0) o = (m_last + j) % 4;
            end
            if (o < 0) begin
                any = 1'b0;
            end else begin
                n = (left[o] < int'(SLOT_LEN)) ? left[o] : int'(SLOT_LEN);
                for (int k = 0; k < n; k++) begin
                    exp_data.push_back(sdata[o][p[o] + k]);
                    exp_owner.push_back(2'(o));
                end
                p[o] += n;
                left[o] -= n;
                m_last = o;
            end
        end
    endtask

    task automatic run_sources();
        int idle, cyc;
        bit done;
        logic [3:0] hs;
        obs_data.delete(); obs_owner.delete(); obs_en.delete(); obs_busy.delete();
        drive_sources();
        idle = 0;
        cyc = 0;
        while (idle < 8 && cyc < 3000) begin
            @(negedge clk);
            obs_en.push_back(tx_en);
            obs_data.push_back(tx_data);
            obs_owner.push_back(tx_owner);
            obs_busy.push_back(busy);
            hs = s_ready & s_valid;
            wait_cycle();
            for (int i = 0; i < 4; i++) if (hs[i]) pos[i]++;
            drive_sources();
            done = 1'b1;
            for (int i = 0; i < 4; i++) if (pos[i] < cnt[i]) done = 1'b0;
            if (done) idle++;
            cyc++;
        end
        checks++;
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL run_timeout cycles %0d required below 3000", cyc);
        end
    endtask

    task automatic compare_stream(input string name);
        int k;
        k = 0;
        for (int c = 0; c < obs_en.size(); c++) begin
            if (obs_en[c]) begin
                if (k < exp_data.size()) begin
                    checks++;
                    if (obs_data[c] !== exp_data[k] || obs_owner[c] !== exp_owner[k]) begin
                        errors++;
                        $display("FAIL %s_beat%0d got owner %0d data %h required owner %0d data %h",
                                 name, k, obs_owner[c], obs_data[c], exp_owner[k], exp_data[k]);
                    end
                end
                k++;
            end
        end
        checks++;
        if (k != exp_data.size()) begin
            errors++;
            $display("FAIL %s_count got %0d samples required %0d", name, k, exp_data.size());
        end
    endtask

    task automatic test_reset();
        s_valid = '1;
        s_data = {$urandom, $urandom};
        #2 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({s_ready, tx_en, tx_data, tx_owner, slot_start, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got rdy %b en %b data %h own %0d ss %b busy %b required all 0",
                         s_ready, tx_en, tx_data, tx_owner, slot_start, busy);
            end
        end
        reset = 1'b1;
        wait_cycle();
        checks++;
        if (slot_start !== 1'b1 || s_ready !== 4'b0001 || tx_owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got ss %b rdy %b own %0d busy %b required 1 0001 0 1",
                     slot_start, s_ready, tx_owner, busy);
        end
        wait_cycle();
        checks++;
        if (slot_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_slot_start_pulse got %b required 0", slot_start);
        end
        s_valid = '0;
        repeat (8) wait_cycle();
    endtask

    task automatic test_single_req();
        int idxq [$];
        int zeros;
        apply_reset();
        load(0, 0, 10, 0, 1'b1);
        build_expected();
        run_sources();
        compare_stream("single");
        for (int c = 0; c < obs_en.size(); c++) if (obs_en[c]) idxq.push_back(c);
        checks++;
        if (idxq.size() < 10) begin
            errors++;
            $display("FAIL single_beats got %0d required 10", idxq.size());
        end else begin
            checks++;
            if (idxq[7] - idxq[0] !== 7) begin
                errors++;
                $display("FAIL single_slot_contiguous got span %0d required 7", idxq[7] - idxq[0]);
            end
            checks++;
            if (idxq[8] - idxq[7] - 1 !== GAP - 1) begin
                errors++;
                $display("FAIL single_gap got %0d idle tx cycles required %0d", idxq[8] - idxq[7] - 1, GAP - 1);
            end
            zeros = 0;
            for (int c = idxq[7]; c < idxq[8]; c++) if (!obs_busy[c]) zeros++;
            checks++;
            if (zeros !== 1) begin
                errors++;
                $display("FAIL single_idle_cycles got %0d required 1", zeros);
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] seq [$];
        logic [1:0] want [5];
        want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        load(10, 10, 10, 10, 1'b0);
        build_expected();
        run_sources();
        compare_stream("rotation");
        for (int c = 0; c < obs_en.size(); c++) begin
            if (obs_en[c] && (seq.size() == 0 || seq[seq.size() - 1] !== obs_owner[c]))
                seq.push_back(obs_owner[c]);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= seq.size() || seq[i] !== want[i]) begin
                errors++;
                $display("FAIL rotation_owner%0d got %0d required %0d", i,
                         (i < seq.size()) ? seq[i] : 2'bxx, want[i]);
            end
        end
    endtask

    task automatic test_early_end();
        int n1, c_end;
        apply_reset();
        load(0, 3, 4, 5, 1'b0);
        build_expected();
        run_sources();
        compare_stream("early");
        n1 = 0;
        c_end = -1;
        for (int c = 0; c < obs_en.size(); c++) begin
            if (obs_en[c] && obs_owner[c] == 2'd1) begin
                n1++;
                if (n1 == 3) c_end = c;
            end
        end
        checks++;
        if (c_end < 0 || c_end + 1 >= obs_en.size() || obs_en[c_end + 1] !== 1'b0) begin
            errors++;
            $display("FAIL early_tx_en_drop got end index %0d required tx_en 0 after third beat", c_end);
        end else begin
            for (int c = c_end + 1; c < obs_en.size(); c++) begin
                if (obs_en[c]) begin
                    checks++;
                    if (obs_owner[c] !== 2'd2) begin
                        errors++;
                        $display("FAIL early_next_owner got %0d required 2", obs_owner[c]);
                    end
                    break;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            load($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 1'b0);
            build_expected();
            run_sources();
            compare_stream($sformatf("random%0d", it));
        end
    endtask

    task automatic test_reset_mid_slot();
        int seen, cyc;
        logic [3:0] hs;
        apply_reset();
        load(0, 0, 0, 20, 1'b0);
        drive_sources();
        seen = 0;
        cyc = 0;
        while (seen < 4 && cyc < 50) begin
            @(negedge clk);
            if (tx_en) seen++;
            if (seen < 4) begin
                hs = s_ready & s_valid;
                wait_cycle();
                for (int i = 0; i < 4; i++) if (hs[i]) pos[i]++;
                drive_sources();
            end
            cyc++;
        end
        checks++;
        if (seen < 4) begin
            errors++;
            $display("FAIL midreset_reach_beat got %0d beats required 4", seen);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx_en !== 1'b0 || s_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort got en %b rdy %b busy %b required 0 0000 0", tx_en, s_ready, busy);
        end
        load(5, 0, 0, 5, 1'b0);
        m_last = 3;
        build_expected();
        drive_sources();
        @(negedge clk) reset = 1'b1;
        wait_cycle();
        checks++;
        if (s_ready !== 4'b0001 || tx_owner !== 2'd0) begin
            errors++;
            $display("FAIL midreset_regrant got rdy %b own %0d required 0001 0", s_ready, tx_owner);
        end
        run_sources();
        compare_stream("midreset");
    endtask

    initial begin
        m_last = 3;
        test_reset();
        test_single_req();
        test_rotation();
        test_early_end();
        test_random();
        test_reset_mid_slot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_tdma_sched.md
# channel_tdma_sched

Time-division scheduler that shares the single 9-bit noisy channel between four sample sources. Each cycle it grants the channel to at most one requester in round-robin order and forwards that requester's samples. It drives the channel's transmit-enable and sample input (`tx_en` → `IsTransmit`, `tx_data` → `channel_in`). It also enforces a maximum slot length and an optional guard gap between slots, so a receiver can separate bursts from the channel noise floor.

## Interface
- `SLOT_LEN`, default 8: maximum accepted samples per slot; legal range 1..255.
- `GUARD_LEN`, default 2: idle cycles after each slot, used only with the guard feature; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  4  bit i: requester i presents a sample.
- `s_data`  in  36  packed samples; requester i uses bits [9i+8:9i].
- `s_ready`  out  4  bit i: requester i's sample is accepted this cycle.
- `tx_en`  out  1  channel transmit enable.
- `tx_data`  out  9  sample driven to the channel.
- `tx_owner`  out  2  index of the current or most recent grantee.
- `slot_start`  out  1  one-cycle pulse in the first SLOT cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The state machine has three states: IDLE, SLOT and GUARD. GUARD exists only with the guard feature.
- IDLE:
  - `s_ready` is 0.
  - If any `s_valid` bit is set, grant the first set bit searching upward (wrapping) from `last_owner`+1.
  - On a grant: latch the index into `owner`/`tx_owner`, clear `beat_cnt`, and go to SLOT.
- SLOT:
  - `s_ready[owner]` equals 1 and is combinational from state only. All other `s_ready` bits are 0.
  - A handshake occurs when `s_valid[owner]` is high in the same cycle.
  - On a handshake: `tx_data` is registered from the owner's data slice, `tx_en` is registered to 1, and `beat_cnt` increments.
  - No handshake (owner's valid low): the slot ends early. `tx_en` goes to 0 and `tx_data` to 0 next cycle.
  - Slot ends when a handshake occurs with `beat_cnt` == `SLOT_LEN`-1, or when an early end occurs.
  - At slot end, `last_owner` is set to `owner` and the FSM moves to GUARD (feature on) or IDLE (feature off).
- GUARD:
  - `tx_en`=0, `tx_data`=0, `s_ready`=0.
  - Counts `GUARD_LEN` cycles, then goes to IDLE.
- Non-owner `s_valid` bits are ignored outside IDLE arbitration.
- `beat_cnt` is 8 bits. `tx_data` is passed through unmodified; no arithmetic is applied.
- Reset values: state IDLE, `last_owner`=3 (so requester 0 wins first), `tx_en`=0, `tx_data`=0, `tx_owner`=0, `slot_start`=0, `busy`=0, `s_ready`=0, all counters 0.
- Reset asserted mid-slot aborts immediately. The next grant restarts from requester 0 priority.

## Timing
- Grant latency: `s_valid` seen in IDLE at cycle N → SLOT and `s_ready` high at N+1, with `slot_start`=1 at N+1.
- Data latency: handshake at cycle M → `tx_en`/`tx_data` valid at M+1 (one register stage).
- A full slot with continuous valid is exactly `SLOT_LEN` handshake cycles.
- Cycle gap from the last SLOT cycle to the next possible SLOT:
  - feature off: 2 (one IDLE cycle, then SLOT);
  - feature on: `GUARD_LEN`+2.
- With continuous demand from all requesters, grants rotate 0,1,2,3,0…
- A sole requester is re-granted after each gap.

## Configuration
- Macro: `CHAN_SCHED_GUARD_EN`.
- Defined: GUARD state is present; every slot is followed by `GUARD_LEN` cycles of `tx_en`=0.
- Undefined: no GUARD state and no guard counter. SLOT goes directly to IDLE, and `GUARD_LEN` is ignored.

## Test plan
- Reset with all valids high:
  - During reset: all outputs 0.
  - After release: `slot_start` and `s_ready`=0001 one cycle later.
  - `tx_owner`=0.
- Single requester 2, continuous valid, samples 1..10, `SLOT_LEN`=8:
  - `tx_data` 1..8 with `tx_en`=1 for 8 cycles.
  - Then the gap.
  - Then a new slot carrying 9, 10.
- All four requesters valid: `tx_owner` sequence 0,1,2,3,0.
- Guard timing, macro defined with `GUARD_LEN`=2: exactly 2 `tx_en`=0 GUARD cycles plus 1 IDLE cycle between slots.
- Guard timing, macro undefined: only 1 IDLE cycle between slots.
- Early end: requester 1 drops valid after 3 beats:
  - Slot ends, `tx_en`=0 next cycle.
  - Next grant goes to requester 2 if it is valid.
- Reset pulse during beat 5 of a slot:
  - `tx_en`=0 immediately.
  - After release, requester 0 is granted first when valid.
